// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory arbiter
package mem_pkg;

    localparam int NUM_CLIENTS = 4;

    typedef enum logic [1:0] {
        SEL_RB1  = 2'd0,
        SEL_RB2  = 2'd1,
        SEL_MASK = 2'd2,
        SEL_WBA  = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GRANT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick, searching from pointer+1
module rr_pick
    import mem_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic [1:0]             i_ptr,
    output logic [NUM_CLIENTS-1:0] o_winner,
    output logic                   o_valid
);

    always_comb begin
        logic [1:0] idx;
        o_winner = '0;
        o_valid  = 1'b0;
        idx      = i_ptr;
        // The pointer itself is checked last, so the previous winner has lowest priority.
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = i_ptr + 2'(k);
            if (!o_valid && i_req[idx]) begin
                o_winner[idx] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin DDR3 client arbiter with outstanding-read drain
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int BURST_LEN       = 1,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [3:0] iREQ,
    output logic [3:0] oGRANT,
    output logic [3:0] oSELECTOR,
    input  logic       iINIT_DONE,
    input  logic       iAVL_READ,
    input  logic       iAVL_WRITE,
    input  logic       iAVL_WAITREQ_N,
    input  logic       iAVL_RDVALID,
    output logic       oBUSY,
    output logic       oERR
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e    r_state, w_state_nxt;
    logic [3:0]    r_grant, w_grant_nxt;
    sel_e          r_sel, w_sel_nxt;
    sel_e          r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_err, w_err_nxt;
    logic [3:0]    w_win;
    logic          w_win_valid;
    sel_e          w_win_idx;
    int            w_net;

    rr_pick u_rr_pick (
        .i_req    (iREQ),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_valid  (w_win_valid)
    );

    always_comb begin
        w_win_idx = SEL_RB1;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_win[i]) w_win_idx = sel_e'(2'(i));
        end
    end

    // Net change first, then clamp, so a coincident read and readdatavalid never flags.
    always_comb begin
        w_net       = int'(r_count) + ((iAVL_READ && iAVL_WAITREQ_N) ? BURST_LEN : 0)
                      - (iAVL_RDVALID ? 1 : 0);
        w_err_nxt   = r_err;
        w_count_nxt = CW'(w_net);
        if (w_net > MAX_OUTSTANDING) begin
            w_count_nxt = CW'(MAX_OUTSTANDING);
            w_err_nxt   = 1'b1;
        end else if (w_net < 0) begin
            w_count_nxt = '0;
            w_err_nxt   = 1'b1;
        end
        if (!iINIT_DONE) begin
            w_count_nxt = '0;
            w_err_nxt   = r_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        if (!iINIT_DONE) begin
            w_state_nxt = ST_INIT;
            w_grant_nxt = '0;
        end else begin
            case (r_state)
                ST_INIT: w_state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (w_win_valid) begin
                        w_state_nxt = ST_GRANT;
                        w_grant_nxt = w_win;
                        w_sel_nxt   = w_win_idx;
                        w_ptr_nxt   = w_win_idx;
                    end
                end
                ST_GRANT: begin
                    if ((iREQ & r_grant) == 4'b0000) begin
                        w_grant_nxt = '0;
                        w_state_nxt = (w_count_nxt != '0) ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= ST_INIT;
            r_grant <= '0;
            r_sel   <= SEL_RB1;
            r_ptr   <= SEL_WBA;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign oGRANT    = r_grant;
    assign oSELECTOR = {2'b00, r_sel};
    assign oBUSY     = (r_state == ST_GRANT) || (r_state == ST_DRAIN);
    assign oERR      = r_err;

    a_no_read_write: assert property (@(posedge iCLK) disable iff (!iRST_n)
        !(iAVL_READ && iAVL_WRITE));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int BURST = 1;
    localparam int MAXO  = 8;
    localparam int M_INIT = 0, M_IDLE = 1, M_GRANT = 2, M_DRAIN = 3;

    logic       iCLK = 1'b0;
    logic       iRST_n = 1'b0;
    logic [3:0] iREQ = 4'b0000;
    logic       iINIT_DONE = 1'b0;
    logic       iAVL_READ = 1'b0;
    logic       iAVL_WRITE = 1'b0;
    logic       iAVL_WAITREQ_N = 1'b0;
    logic       iAVL_RDVALID = 1'b0;
    logic [3:0] oGRANT;
    logic [3:0] oSELECTOR;
    logic       oBUSY;
    logic       oERR;

    int checks = 0;
    int failures = 0;

    int m_mode, m_owner, m_ptr, m_sel, m_cnt, m_err;

    typedef struct packed {
        logic       init;
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] sel;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    always #5 iCLK = ~iCLK;

    mem_arbiter #(.BURST_LEN(BURST), .MAX_OUTSTANDING(MAXO)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iREQ(iREQ), .oGRANT(oGRANT), .oSELECTOR(oSELECTOR),
        .iINIT_DONE(iINIT_DONE), .iAVL_READ(iAVL_READ), .iAVL_WRITE(iAVL_WRITE),
        .iAVL_WAITREQ_N(iAVL_WAITREQ_N), .iAVL_RDVALID(iAVL_RDVALID),
        .oBUSY(oBUSY), .oERR(oERR)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT; m_owner = -1; m_ptr = 3; m_sel = 0; m_cnt = 0; m_err = 0;
    endtask

    // Reference behaviour: outstanding reads tracked as a plain integer, grant owner as a client number.
    task automatic model_edge();
        int net;
        if (!iINIT_DONE) begin
            m_mode = M_INIT; m_owner = -1; m_cnt = 0;
            return;
        end
        net = m_cnt + ((iAVL_READ && iAVL_WAITREQ_N) ? BURST : 0) - (iAVL_RDVALID ? 1 : 0);
        if (net > MAXO) begin net = MAXO; m_err = 1; end
        if (net < 0) begin net = 0; m_err = 1; end
        case (m_mode)
            M_INIT: m_mode = M_IDLE;
            M_IDLE: begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_ptr + k) % 4;
                    if (m_mode == M_IDLE && iREQ[c]) begin
                        m_owner = c; m_ptr = c; m_sel = c; m_mode = M_GRANT;
                    end
                end
            end
            M_GRANT: begin
                if (!iREQ[m_owner]) begin
                    m_owner = -1;
                    m_mode = (net > 0) ? M_DRAIN : M_IDLE;
                end
            end
            default: if (net == 0) m_mode = M_IDLE;
        endcase
        m_cnt = net;
    endtask

    task automatic check_model();
        chk("model_grant", int'(oGRANT), (m_owner < 0) ? 0 : (1 << m_owner));
        chk("model_sel", int'(oSELECTOR), m_sel);
        chk("model_busy", int'(oBUSY), (m_mode == M_GRANT || m_mode == M_DRAIN) ? 1 : 0);
        chk("model_err", int'(oERR), m_err);
        chk("model_count", int'(dut.r_count), m_cnt);
    endtask

    task automatic tick();
        @(posedge iCLK);
        if (!iRST_n) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    task automatic add(input logic init, input logic [3:0] req, input logic [3:0] grant,
                       input logic [3:0] sel, input logic busy);
        vec_t v;
        v.init = init; v.req = req; v.grant = grant; v.sel = sel; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic async_reset(input string tag);
        #3;
        iRST_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_grant"}, int'(oGRANT), 0);
        chk({tag, "_sel"}, int'(oSELECTOR), 0);
        chk({tag, "_busy"}, int'(oBUSY), 0);
        chk({tag, "_err"}, int'(oERR), 0);
        chk({tag, "_count"}, int'(dut.r_count), 0);
        tick();
        iRST_n = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 10; i++) add(1'b0, 4'b0001, 4'b0000, 4'd0, 1'b0);
        add(1'b1, 4'b0001, 4'b0000, 4'd0, 1'b0);
        add(1'b1, 4'b0001, 4'b0001, 4'd0, 1'b1);
        add(1'b1, 4'b1111, 4'b0001, 4'd0, 1'b1);
        add(1'b1, 4'b1111, 4'b0001, 4'd0, 1'b1);
        add(1'b1, 4'b1110, 4'b0000, 4'd0, 1'b0);
        for (int c = 1; c < 4; c++) begin
            logic [3:0] oh;
            oh = 4'(1 << c);
            for (int r = 0; r < 3; r++) add(1'b1, 4'b1111, oh, 4'(c), 1'b1);
            add(1'b1, 4'b1111 & ~oh, 4'b0000, 4'(c), 1'b0);
        end
        add(1'b1, 4'b1111, 4'b0001, 4'd0, 1'b1);
        add(1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0);

        tick(); tick();
        chk("reset_grant", int'(oGRANT), 0);
        chk("reset_sel", int'(oSELECTOR), 0);
        chk("reset_busy", int'(oBUSY), 0);
        chk("reset_err", int'(oERR), 0);
        iRST_n = 1'b1;

        foreach (tbl[i]) begin
            iINIT_DONE = tbl[i].init;
            iREQ = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_grant", i), int'(oGRANT), int'(tbl[i].grant));
            chk($sformatf("tbl%0d_sel", i), int'(oSELECTOR), int'(tbl[i].sel));
            chk($sformatf("tbl%0d_busy", i), int'(oBUSY), int'(tbl[i].busy));
        end

        // Drain after three reads by rb2, with rb1 asking during the drain.
        iREQ = 4'b0010; tick();
        chk("drain_grant", int'(oGRANT), 4'b0010);
        iAVL_READ = 1'b1; iAVL_WAITREQ_N = 1'b1;
        repeat (3) tick();
        iAVL_READ = 1'b0; iREQ = 4'b0000; tick();
        chk("drain_enter_busy", int'(oBUSY), 1);
        chk("drain_enter_grant", int'(oGRANT), 0);
        iREQ = 4'b0001; tick();
        chk("drain_req_ignored", int'(oGRANT), 0);
        iAVL_RDVALID = 1'b1; tick(); tick();
        chk("drain_sel_held", int'(oSELECTOR), 1);
        chk("drain_busy_held", int'(oBUSY), 1);
        tick();
        chk("drain_exit_busy", int'(oBUSY), 0);
        chk("drain_exit_grant", int'(oGRANT), 0);
        chk("drain_exit_sel", int'(oSELECTOR), 1);
        iAVL_RDVALID = 1'b0; tick();
        chk("drain_post_grant", int'(oGRANT), 4'b0001);

        // Coincident accepted read and readdatavalid at count 2.
        iAVL_READ = 1'b1; tick(); tick();
        iAVL_RDVALID = 1'b1; tick();
        chk("net_count", int'(dut.r_count), 2);
        chk("net_err", int'(oERR), 0);
        iAVL_READ = 1'b0; iREQ = 4'b0000; tick(); tick();
        iAVL_RDVALID = 1'b0; tick();
        chk("net_idle_busy", int'(oBUSY), 0);

        // Underflow, stickiness, saturation, then init loss keeps the flag.
        iAVL_RDVALID = 1'b1; tick();
        chk("underflow_err", int'(oERR), 1);
        chk("underflow_count", int'(dut.r_count), 0);
        iAVL_RDVALID = 1'b0; repeat (3) tick();
        chk("err_sticky", int'(oERR), 1);
        iAVL_READ = 1'b1; repeat (9) tick();
        iAVL_READ = 1'b0;
        chk("sat_count", int'(dut.r_count), 8);
        chk("sat_err", int'(oERR), 1);
        iINIT_DONE = 1'b0; tick();
        chk("initlow_count", int'(dut.r_count), 0);
        chk("initlow_err", int'(oERR), 1);
        iINIT_DONE = 1'b1; tick();

        // Asynchronous reset in the middle of a grant with five reads outstanding.
        iREQ = 4'b1000; tick();
        chk("rst_pre_grant", int'(oGRANT), 4'b1000);
        iAVL_READ = 1'b1; repeat (5) tick();
        iAVL_READ = 1'b0;
        chk("rst_pre_count", int'(dut.r_count), 5);
        async_reset("rst_mid");
        iREQ = 4'b0000;

        for (int n = 0; n < 3000; n++) begin
            iREQ = 4'($urandom_range(0, 15));
            iINIT_DONE = ($urandom_range(0, 99) != 0);
            iAVL_READ = ($urandom_range(0, 3) == 0);
            iAVL_WAITREQ_N = 1'($urandom_range(0, 1));
            iAVL_RDVALID = ($urandom_range(0, 3) == 0);
            iAVL_WRITE = iAVL_READ ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
